// File: rtl/can_framer_pkg.sv
// Shared types for the CAN-receive to UART framer: FSM states, header layout and frame slot.
// The slot carries a timestamp only when CAN_FRAMER_TIMESTAMP_EN is defined.
package can_framer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_HDR,
    ST_ID,
    ST_TS,
    ST_DATA,
    ST_CSUM
  } state_t;

  localparam int MAX_LEN     = 8;
  localparam int HDR_CH_LSB  = 6;
  localparam int HDR_IDE_BIT = 5;
  localparam int HDR_TS_BIT  = 4;
  localparam int HDR_LEN_LSB = 0;

  typedef struct packed {
    logic [MAX_LEN-1:0][7:0] data;
    logic [3:0]              len;
    logic [28:0]             id;
    logic                    ide;
`ifdef CAN_FRAMER_TIMESTAMP_EN
    logic [15:0]             ts;
`endif
  } slot_t;

  function automatic logic [7:0] make_hdr(input logic [1:0] ch, input logic ide,
                                          input logic ts_en, input logic [3:0] len);
    logic [7:0] h;
    h = '0;
    h[HDR_CH_LSB +: 2]  = ch;
    h[HDR_IDE_BIT]      = ide;
    h[HDR_TS_BIT]       = ts_en;
    h[HDR_LEN_LSB +: 4] = len;
    return h;
  endfunction

  // Big-endian ID byte: standard IDs use the low two bytes of the 32-bit word, extended all four.
  function automatic logic [7:0] id_byte(input logic [28:0] id, input logic ide,
                                         input logic [1:0] idx);
    logic [31:0] w;
    logic [1:0]  pos;
    w   = ide ? {3'b0, id} : {21'b0, id[10:0]};
    pos = ide ? idx : idx + 2'd2;
    case (pos)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

endpackage

// File: rtl/can_rx_chan_buf.sv
// One CAN channel: capture buffer, single pending slot, commit/drop decision and
// saturating drop counter. With CAN_FRAMER_TIMESTAMP_EN the commit also stores ts_now.
module can_rx_chan_buf
  import can_framer_pkg::*;
#(
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rx_valid,
  input  logic              rx_last,
  input  logic [7:0]        rx_data,
  input  logic [28:0]       rx_id,
  input  logic              rx_ide,
`ifdef CAN_FRAMER_TIMESTAMP_EN
  input  logic [15:0]       ts_now,
`endif
  input  logic              free,
  output logic              pending,
  output slot_t             slot,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam logic [3:0] LEN_MAX = 4'(MAX_LEN);

  logic [MAX_LEN-1:0][7:0] cap_data, frame_data;
  logic [3:0]              cap_len, frame_len;
  logic [28:0]             cap_id, frame_id;
  logic                    cap_ide, frame_ide;
  slot_t                   slot_nxt;
  logic                    commit;

  // Frame as it would look after absorbing this cycle's byte; ID is taken from the first byte.
  always_comb begin
    frame_data = cap_data;
    frame_len  = cap_len;
    frame_id   = cap_id;
    frame_ide  = cap_ide;
    if (cap_len == 4'd0) begin
      frame_id  = rx_id;
      frame_ide = rx_ide;
    end
    if (cap_len < LEN_MAX) begin
      frame_data[cap_len[2:0]] = rx_data;
      frame_len                = cap_len + 4'd1;
    end
    slot_nxt      = '0;
    slot_nxt.data = frame_data;
    slot_nxt.len  = frame_len;
    slot_nxt.id   = frame_id;
    slot_nxt.ide  = frame_ide;
`ifdef CAN_FRAMER_TIMESTAMP_EN
    slot_nxt.ts   = ts_now;
`endif
  end

  assign commit = rx_valid & rx_last;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cap_data <= '0;
      cap_len  <= '0;
      cap_id   <= '0;
      cap_ide  <= 1'b0;
      pending  <= 1'b0;
      slot     <= '0;
      drop_cnt <= '0;
    end else begin
      if (commit) begin
        cap_data <= '0;
        cap_len  <= '0;
        cap_id   <= '0;
        cap_ide  <= 1'b0;
      end else if (rx_valid) begin
        cap_data <= frame_data;
        cap_len  <= frame_len;
        cap_id   <= frame_id;
        cap_ide  <= frame_ide;
      end
      // A slot being freed this cycle is treated as empty so the commit still lands.
      if (commit && (!pending || free)) begin
        pending <= 1'b1;
        slot    <= slot_nxt;
      end else if (commit) begin
        if (drop_cnt != {DROP_W{1'b1}}) drop_cnt <= drop_cnt + 1'b1;
      end else if (free) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/can_rx_uart_framer.sv
// Multi-channel CAN-receive framer: round-robin over pending slots, emits SYNC/HDR/ID/DATA/CSUM
// into a uart_tx write port. Define CAN_FRAMER_TIMESTAMP_EN to add a 2-byte TS field.
module can_rx_uart_framer
  import can_framer_pkg::*;
#(
  parameter int         NCH       = 2,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         DROP_W    = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NCH-1:0]        rx_valid,
  input  logic [NCH-1:0]        rx_last,
  input  logic [NCH*8-1:0]      rx_data,
  input  logic [NCH*29-1:0]     rx_id,
  input  logic [NCH-1:0]        rx_ide,
  output logic                  o_wreq,
  input  logic                  i_wgnt,
  output logic [7:0]            o_wdata,
  output logic [NCH*DROP_W-1:0] drop_cnt,
  output logic                  busy
);

`ifdef CAN_FRAMER_TIMESTAMP_EN
  localparam logic TS_EN = 1'b1;
  logic [15:0] ts_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ts_cnt <= '0;
    else       ts_cnt <= ts_cnt + 16'd1;
  end
`else
  localparam logic TS_EN = 1'b0;
`endif

  state_t         state;
  logic [1:0]     sel, rr_ptr, pick, rr_next;
  logic           found, xfer;
  logic [3:0]     idx, idx_inc;
  logic [7:0]     csum;
  logic [NCH-1:0] pending, free;
  slot_t          slots [NCH];
  slot_t          cur;
  logic [7:0]     hdr_byte, id_first, id_next, data_next;
  logic [1:0]     id_last;

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    can_rx_chan_buf #(.DROP_W(DROP_W)) u_buf (
      .clk      (clk),
      .rstn     (rstn),
      .rx_valid (rx_valid[c]),
      .rx_last  (rx_last[c]),
      .rx_data  (rx_data[8*c +: 8]),
      .rx_id    (rx_id[29*c +: 29]),
      .rx_ide   (rx_ide[c]),
`ifdef CAN_FRAMER_TIMESTAMP_EN
      .ts_now   (ts_cnt),
`endif
      .free     (free[c]),
      .pending  (pending[c]),
      .slot     (slots[c]),
      .drop_cnt (drop_cnt[DROP_W*c +: DROP_W])
    );
  end

  assign xfer = o_wreq & i_wgnt;
  assign busy = (state != ST_IDLE) || (|pending);

  // Round-robin search starts at rr_ptr, which follows the channel served last.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr;
    for (int k = 0; k < NCH; k++) begin
      if (!found && pending[(int'(rr_ptr) + k) % NCH]) begin
        found = 1'b1;
        pick  = 2'((int'(rr_ptr) + k) % NCH);
      end
    end
    rr_next = 2'((int'(sel) + 1) % NCH);
    cur  = '0;
    free = '0;
    for (int c = 0; c < NCH; c++) begin
      if (sel == 2'(c)) cur = slots[c];
      free[c] = xfer && (state == ST_CSUM) && (sel == 2'(c));
    end
    idx_inc   = idx + 4'd1;
    id_last   = cur.ide ? 2'd3 : 2'd1;
    hdr_byte  = make_hdr(sel, cur.ide, TS_EN, cur.len);
    id_first  = id_byte(cur.id, cur.ide, 2'd0);
    id_next   = id_byte(cur.id, cur.ide, idx_inc[1:0]);
    data_next = cur.data[idx_inc[2:0]];
  end

  // Each emitting state holds o_wdata until accepted; csum accumulates every byte as it is loaded.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      sel     <= '0;
      rr_ptr  <= '0;
      idx     <= '0;
      csum    <= '0;
      o_wreq  <= 1'b0;
      o_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: if (found) begin
          sel     <= pick;
          state   <= ST_SYNC;
          o_wreq  <= 1'b1;
          o_wdata <= SYNC_BYTE;
        end
        ST_SYNC: if (xfer) begin
          state   <= ST_HDR;
          o_wdata <= hdr_byte;
          csum    <= hdr_byte;
        end
        ST_HDR: if (xfer) begin
          state   <= ST_ID;
          idx     <= '0;
          o_wdata <= id_first;
          csum    <= csum + id_first;
        end
        ST_ID: if (xfer) begin
          if (idx[1:0] != id_last) begin
            idx     <= idx_inc;
            o_wdata <= id_next;
            csum    <= csum + id_next;
          end else begin
`ifdef CAN_FRAMER_TIMESTAMP_EN
            state   <= ST_TS;
            idx     <= '0;
            o_wdata <= cur.ts[15:8];
            csum    <= csum + cur.ts[15:8];
`else
            idx <= '0;
            if (cur.len == 4'd0) begin
              state   <= ST_CSUM;
              o_wdata <= csum;
            end else begin
              state   <= ST_DATA;
              o_wdata <= cur.data[0];
              csum    <= csum + cur.data[0];
            end
`endif
          end
        end
`ifdef CAN_FRAMER_TIMESTAMP_EN
        ST_TS: if (xfer) begin
          if (idx == 4'd0) begin
            idx     <= 4'd1;
            o_wdata <= cur.ts[7:0];
            csum    <= csum + cur.ts[7:0];
          end else begin
            idx <= '0;
            if (cur.len == 4'd0) begin
              state   <= ST_CSUM;
              o_wdata <= csum;
            end else begin
              state   <= ST_DATA;
              o_wdata <= cur.data[0];
              csum    <= csum + cur.data[0];
            end
          end
        end
`endif
        ST_DATA: if (xfer) begin
          if (idx_inc == cur.len) begin
            state   <= ST_CSUM;
            o_wdata <= csum;
          end else begin
            idx     <= idx_inc;
            o_wdata <= data_next;
            csum    <= csum + data_next;
          end
        end
        ST_CSUM: if (xfer) begin
          state  <= ST_IDLE;
          o_wreq <= 1'b0;
          rr_ptr <= rr_next;
        end
        default: begin
          state  <= ST_IDLE;
          o_wreq <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/can_rx_uart_framer.md
Name: can_rx_uart_framer

Overview:
Multi-channel CAN-receive to UART-byte-stream framer. It sits between NCH CAN controllers (byte-stream rx outputs) and one uart_tx write port. It reassembles each received CAN frame per channel and serialises it as a self-delimiting packet: sync, header, ID, data, checksum. Arbitration across channels is round-robin, and the output obeys uart_tx backpressure, so the host can tell frames, channels and IDs apart.

Parameters:
NCH, 2, number of CAN channels (1..4)
SYNC_BYTE, 8'hA5, packet start marker
DROP_W, 8, width of each per-channel saturating drop counter

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
rx_valid  in  NCH  per-channel byte strobe from CAN controller
rx_last  in  NCH  per-channel last byte of frame (qualified by rx_valid)
rx_data  in  NCH*8  per-channel data byte; channel c at [8c+7:8c]
rx_id  in  NCH*29  per-channel frame ID; standard ID in [10:0]
rx_ide  in  NCH  per-channel: 1 = extended ID
o_wreq  out  1  output byte valid (to uart_tx wreq)
i_wgnt  in  1  byte accepted (from uart_tx wgnt)
o_wdata  out  8  output byte
drop_cnt  out  NCH*DROP_W  per-channel count of dropped frames, saturating
busy  out  1  1 while any frame is pending or being serialised

Behaviour:
- Reset: o_wreq=0, o_wdata=0, drop_cnt=0, busy=0, all buffers empty, FSM IDLE, round-robin pointer=0.
- Per channel: one capture buffer and one pending slot. Each slot holds 8 bytes, len[3:0], id[28:0] and ide.
- Capture: rx_id and rx_ide are latched on the first byte of a frame. Bytes append at index len. After 8 bytes, further bytes are discarded and len stays 8.
- Commit: on rx_valid&rx_last, the capture buffer, including this byte, moves to pending if pending is empty. Otherwise the frame is dropped and drop_cnt[c] increments, saturating at all-ones. The capture buffer is cleared either way.
- Same-cycle free: pending freed by CSUM acceptance in the same cycle as a commit counts as empty, so the commit succeeds.
- Handshake: a byte transfers when o_wreq&i_wgnt. While o_wreq=1 and i_wgnt=0, o_wdata is held stable.
- FSM states: IDLE, SYNC, HDR, ID, DATA, CSUM.
- IDLE: if any pending is set, register the selected channel by round-robin, starting at (last served + 1) mod NCH, then go to SYNC.
- Each emitting state holds until its byte is accepted.
- SYNC byte = SYNC_BYTE.
- HDR byte = {ch[1:0], ide, 1'b0, len[3:0]}.
- ID bytes, big-endian: 2 bytes when ide=0 ({5'b0, id[10:0]}); 4 bytes when ide=1 ({3'b0, id[28:0]}).
- DATA: len bytes in receive order.
- CSUM = 8-bit modulo-256 sum of all bytes from HDR through the last DATA byte. SYNC is excluded.
- On CSUM acceptance: clear that channel's pending slot, then go to IDLE.
- Latency: o_wreq rises at most 2 cycles after the commit cycle if the FSM is IDLE. There is no idle gap is required between back-to-back packets beyond the single IDLE cycle.
- busy = (FSM != IDLE) or any pending set.
- Mid-frame reset: everything clears asynchronously, and a partial packet is abandoned. The host resynchronises on SYNC_BYTE.
- rx_valid on two channels in the same cycle is independent; there is no interaction.

Optional Feature:
CAN_FRAMER_TIMESTAMP_EN
- Defined:
  - A free-running 16-bit counter runs on clk and is captured into the slot at commit.
  - State TS is inserted between ID and DATA and emits 2 bytes, big-endian.
  - The TS bytes are included in CSUM.
  - HDR bit 4 = 1.
- Undefined: no counter, no TS state, HDR bit 4 = 0.

Decomposition:
- Package can_framer_pkg holds: the FSM state enum, HDR field positions, the MAX_LEN=8 constant, and the slot struct (data[8][8], len, id, ide, ts).
- Sub-module can_rx_chan_buf, instantiated NCH times, contains the capture buffer, pending slot, commit/drop logic and drop counter. It exposes pending, the slot contents and a free strobe.

Test Plan:
1. ch0, ide=0, id 0x123, data 01 02 03, i_wgnt=1 -> bytes A5 03 01 23 01 02 03 2D; busy returns to 0.
2. ch1, ide=1, id 0x12345678, data AA -> bytes A5 61 12 34 56 78 AA 1F.
3. Hold i_wgnt=0 for 100 cycles mid-DATA -> o_wreq stays 1 and o_wdata is unchanged; the stream resumes intact when i_wgnt returns to 1.
4. ch0: three 1-byte frames back to back with i_wgnt=0 -> the first is pending, the second is dropped (drop_cnt[0]=1), the third is dropped (drop_cnt[0]=2). After i_wgnt=1, exactly one packet is emitted.
5. ch0 and ch1 commit in the same cycle, then ch0 commits again during service -> output order ch0, ch1, ch0.
6. A 10-byte burst with rx_last on the 10th byte -> len=8, first 8 bytes emitted; assert rstn mid-ID -> o_wreq=0 immediately and drop_cnt=0.
